// File: rtl/argmax_classifier_pkg.sv
// Shared constants and types for the argmax output-layer classifier.
package argmax_classifier_pkg;

    // Default network shape: ten output-layer scores in signed Q8.8.
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_DATA_W      = 16;

    // Width of the winning-class index presented to the consumer.
    localparam int IDX_W = 4;

    // Most negative Q8.8 value; seeds the runner-up so any real score can displace it.
    localparam logic [DEF_DATA_W-1:0] SCORE_MIN = 16'h8000;

    // Classifier controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_classifier_compare.sv
// One step of the running max / runner-up search over signed scores.
module argmax_compare_unit #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic [DATA_W-1:0] best,
    input  logic [DATA_W-1:0] second,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DATA_W-1:0] score,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] next_best,
    output logic [DATA_W-1:0] next_second,
    output logic [IDX_W-1:0]  next_idx
);

    // Strict greater-than keeps the earliest index on ties and lets an equal score become the runner-up.
    always_comb begin
        next_best   = best;
        next_second = second;
        next_idx    = best_idx;
        if ($signed(score) > $signed(best)) begin
            next_second = best;
            next_best   = score;
            next_idx    = idx;
        end else if ($signed(score) > $signed(second)) begin
            next_second = score;
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Argmax classifier: snapshots the output-layer scores on start, scans one
// class per cycle, and presents winner, its score and the margin to the
// runner-up through a valid/ready handshake.
module argmax_classifier
    import argmax_classifier_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLASSES*DATA_W-1:0] scores,
    input  logic                          start,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              class_idx,
    output logic [DATA_W-1:0]             max_score,
    output logic [DATA_W-1:0]             margin
);

    // Counter must reach NUM_CLASSES so the cycle after the last compare can publish the result.
    localparam int CNT_W = $clog2(NUM_CLASSES + 1);

    state_t                        state;
    logic [NUM_CLASSES*DATA_W-1:0] snap;
    logic [DATA_W-1:0]             best;
    logic [DATA_W-1:0]             second;
    logic [IDX_W-1:0]              best_idx;
    logic [CNT_W-1:0]              scan_idx;

    logic [DATA_W-1:0]             cur_score;
    logic [DATA_W-1:0]             nxt_best;
    logic [DATA_W-1:0]             nxt_second;
    logic [IDX_W-1:0]              nxt_idx;

    // Select the snapshot entry addressed by the scan counter (zero once past the last class).
    always_comb begin
        cur_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (scan_idx == CNT_W'(k)) begin
                cur_score = snap[k*DATA_W +: DATA_W];
            end
        end
    end

    argmax_compare_unit #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_compare (
        .best        (best),
        .second      (second),
        .best_idx    (best_idx),
        .score       (cur_score),
        .idx         (IDX_W'(scan_idx)),
        .next_best   (nxt_best),
        .next_second (nxt_second),
        .next_idx    (nxt_idx)
    );

    // Controller: snapshot on start, one compare per cycle, publish, then hold until the consumer accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            snap      <= '0;
            best      <= '0;
            second    <= '0;
            best_idx  <= '0;
            scan_idx  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            class_idx <= '0;
            max_score <= '0;
            margin    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= scores;
                        best     <= scores[DATA_W-1:0];
                        best_idx <= '0;
                        second   <= DATA_W'(SCORE_MIN);
                        scan_idx <= CNT_W'(1);
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_idx == CNT_W'(NUM_CLASSES)) begin
                        class_idx <= best_idx;
                        max_score <= best;
                        margin    <= best - second;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        best     <= nxt_best;
                        second   <= nxt_second;
                        best_idx <= nxt_idx;
                        scan_idx <= scan_idx + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
